ofs_plat_host_chan_gen_rd_req_split: RTL and testbench
======================================================

# ofs_plat_host_chan_gen_rd_req_split

Splits AFU read requests into PCIe-legal read chunks ahead of the read-TLP generator. Each chunk is at most `MAX_RD_REQ_LINES` lines and never crosses a 4KB page. Each chunk carries the original AFU tag plus its line offset and first/last markers, so the completion path can rebuild line indices and a single final `last`. The block sits between the AFU request FIFO and the read-TLP generation stage in the host-channel read pipeline.

## Interface
Parameters:
- `ADDR_WIDTH`, 64, byte address width; addresses are 64B-line aligned.
- `TAG_WIDTH`, 9, AFU tag width.
- `MAX_AFU_LINES`, 64, largest AFU request in lines.
- `LC_WIDTH`, `$clog2(MAX_AFU_LINES+1)`, line-count width.
- `MAX_RD_REQ_LINES`, 8, chunk size cap in lines (power of 2, ≤ 64).

Ports:
- `clk` in 1 — the single clock.
- `reset` in 1 — synchronous, active-high.
- `in_valid` in 1 — AFU request valid.
- `in_ready` out 1 — request accepted when high with `in_valid`.
- `in_addr` in `ADDR_WIDTH` — byte start address.
- `in_tag` in `TAG_WIDTH` — AFU tag.
- `in_line_count` in `LC_WIDTH` — lines requested, 1..`MAX_AFU_LINES`.
- `out_valid` out 1 — chunk valid.
- `out_ready` in 1 — downstream accepts the chunk.
- `out_addr` out `ADDR_WIDTH` — chunk start address.
- `out_tag` out `TAG_WIDTH` — copy of `in_tag`.
- `out_line_count` out `LC_WIDTH` — chunk length in lines.
- `out_line_offset` out `LC_WIDTH` — line index of the chunk within the AFU request.
- `out_sop` out 1 — first chunk of the request.
- `out_eop` out 1 — final chunk of the request.

## Operation
Source selection:
- Working state: `rem_lines`, `cur_addr`, `cur_tag`, `cur_offset`.
- `rem_lines==0` means idle; otherwise the block is splitting.
- Chunk source is the new input when idle; otherwise the working state.

Chunk length: `len = min(remaining, MAX_RD_REQ_LINES, page_lines)`.
- `page_lines = 64 - addr[11:6]`, range 1..64.
- All arithmetic is unsigned at `LC_WIDTH+1` bits; no truncation before the min.

Chunk fields:
- `out_sop` = chunk came from a new input.
- `out_eop` = `len == remaining`.
- `out_line_offset` = 0 for the first chunk, else `cur_offset`.

State update when a chunk loads into the output register:
- `cur_addr += len*64`
- `cur_offset += len`
- `rem_lines = remaining - len`

Handshake:
- `in_ready = (rem_lines==0) && (!out_valid || out_ready)`.
- The output register loads when `(!out_valid || out_ready)` and a chunk source exists.
- Output fields hold stable while `out_valid && !out_ready`.

States:
- IDLE: `rem_lines==0`.
- SPLIT: `rem_lines!=0`.
- IDLE→SPLIT on accepting a request that needs more than one chunk.
- SPLIT→IDLE when the chunk with `out_eop` loads.
- A single-chunk request never leaves IDLE.

Boundaries:
- `in_line_count==0` is illegal; simulation-only assertion, fatal.
- An address in the top 4KB of `ADDR_WIDTH` wraps modulo 2^`ADDR_WIDTH`.
- A request arriving while an eop chunk drains is accepted the same cycle.

## Timing
- Reset values: `out_valid=0`, `rem_lines=0`, `cur_offset=0`. `in_ready` is 1 one cycle after reset deasserts. Data outputs are don't-care while `out_valid=0`.
- Latency: input accepted in cycle N gives the first chunk with `out_valid` in cycle N+1.
- Throughput: one chunk per cycle with `out_ready` held high. Back-to-back single-chunk requests sustain 1/cycle.
- Reset asserted mid-split drops remaining chunks and the pending output. No partial request is emitted after reset.

## Configuration
- `OFS_PLAT_HOST_CHAN_RD_SPLIT_PAGE_CHECK_EN` defined: the 4KB page limit applies as above.
- Undefined: `page_lines` is treated as ∞. Chunks split only on `MAX_RD_REQ_LINES`, for AFUs that guarantee page-aligned requests. This saves the subtractor and compare.

## Structure
- Shared package `ofs_plat_host_chan_gen_rd_split_pkg` holds:
  - `t_rd_split_req`: addr, tag, line_count.
  - `t_rd_split_chunk`: adds line_offset, sop, eop.
  - `PAGE_LINES=64`, `LINE_BYTES=64`.
  - Function `chunkLines(addr, remaining)`.
- The package is shared with the completion path.
- One sub-module: `ofs_plat_host_chan_rd_split_len`, a combinational min-of-three length calculator. It is reused by the write splitter.

## Test plan
- addr 0x1000, 8 lines, `MAX_RD_REQ_LINES`=8 → one chunk: 0x1000, 8 lines, offset 0, sop=1, eop=1.
- addr 0x0, 20 lines → three chunks:
  - 0x0, 8 lines, offset 0, sop=1
  - 0x200, 8 lines, offset 8
  - 0x400, 4 lines, offset 16, eop=1
- addr 0x1FC0, 4 lines, macro on → two chunks: 0x1FC0 1 line eop=0, then 0x2000 3 lines offset 1 eop=1. Macro off → one chunk of 4 lines.
- 20-line request with `out_ready` low for 5 cycles at the second chunk → chunk 0x200 held stable; `in_ready`=0 throughout; chunks resume in order.
- 16 back-to-back 1-line requests, `out_ready`=1 → 16 chunks in 16 consecutive cycles, tags in order.
- `reset` pulsed after the first chunk of a 20-line request → `out_valid`=0 the next cycle, no further chunks, `in_ready`=1 afterwards.

Source files
------------

// File: rtl/ofs_plat_host_chan_gen_rd_split_pkg.sv
// Shared types and helpers for the host-channel read splitter and its completion path.
// OFS_PLAT_HOST_CHAN_RD_SPLIT_PAGE_CHECK_EN enables the 4KB page limit on chunks.
package ofs_plat_host_chan_gen_rd_split_pkg;

  localparam int RD_SPLIT_ADDR_WIDTH = 64;
  localparam int RD_SPLIT_TAG_WIDTH = 9;
  localparam int RD_SPLIT_LC_WIDTH = 7;
  localparam int DEFAULT_MAX_RD_REQ_LINES = 8;

  localparam int PAGE_LINES = 64;
  localparam int LINE_BYTES = 64;

`ifdef OFS_PLAT_HOST_CHAN_RD_SPLIT_PAGE_CHECK_EN
  localparam bit PAGE_CHECK_EN = 1'b1;
`else
  localparam bit PAGE_CHECK_EN = 1'b0;
`endif

  typedef enum logic {
    ST_IDLE,
    ST_SPLIT
  } t_rd_split_state;

  typedef struct packed {
    logic [RD_SPLIT_ADDR_WIDTH-1:0] addr;
    logic [RD_SPLIT_TAG_WIDTH-1:0]  tag;
    logic [RD_SPLIT_LC_WIDTH-1:0]   line_count;
  } t_rd_split_req;

  typedef struct packed {
    logic [RD_SPLIT_ADDR_WIDTH-1:0] addr;
    logic [RD_SPLIT_TAG_WIDTH-1:0]  tag;
    logic [RD_SPLIT_LC_WIDTH-1:0]   line_count;
    logic [RD_SPLIT_LC_WIDTH-1:0]   line_offset;
    logic                           sop;
    logic                           eop;
  } t_rd_split_chunk;

  // Length of the next chunk starting at addr with remaining lines left.
  function automatic int unsigned chunkLines(
    input logic [RD_SPLIT_ADDR_WIDTH-1:0] addr,
    input int unsigned                    remaining,
    input int unsigned                    maxLines = DEFAULT_MAX_RD_REQ_LINES
  );
    int unsigned len;
    int unsigned pageRoom;
    len = (remaining < maxLines) ? remaining : maxLines;
    pageRoom = PAGE_LINES - int'(addr[11:6]);
    if (PAGE_CHECK_EN && (pageRoom < len)) len = pageRoom;
    return len;
  endfunction

endpackage

// File: rtl/ofs_plat_host_chan_rd_split_len.sv
// Combinational min-of-three chunk length: remaining, chunk cap and lines left in the page.
// The page term exists only with OFS_PLAT_HOST_CHAN_RD_SPLIT_PAGE_CHECK_EN defined.
module ofs_plat_host_chan_rd_split_len
  import ofs_plat_host_chan_gen_rd_split_pkg::*;
#(
  parameter int LC_WIDTH = 7,
  parameter int MAX_RD_REQ_LINES = 8
)
(
`ifdef OFS_PLAT_HOST_CHAN_RD_SPLIT_PAGE_CHECK_EN
  input  logic [5:0]        page_line_idx_i,
`endif
  input  logic [LC_WIDTH:0] remaining_i,
  output logic [LC_WIDTH:0] len_o
);

  localparam logic [LC_WIDTH:0] MAX_LINES = (LC_WIDTH+1)'(MAX_RD_REQ_LINES);

`ifdef OFS_PLAT_HOST_CHAN_RD_SPLIT_PAGE_CHECK_EN
  logic [LC_WIDTH:0] pageLines;
  assign pageLines = (LC_WIDTH+1)'(PAGE_LINES) - (LC_WIDTH+1)'(page_line_idx_i);
`endif

  always_comb begin
    len_o = (remaining_i < MAX_LINES) ? remaining_i : MAX_LINES;
`ifdef OFS_PLAT_HOST_CHAN_RD_SPLIT_PAGE_CHECK_EN
    if (pageLines < len_o) len_o = pageLines;
`endif
  end

endmodule

// File: rtl/ofs_plat_host_chan_gen_rd_req_split.sv
// Splits AFU read requests into capped, optionally page-bounded chunks for TLP generation.
// OFS_PLAT_HOST_CHAN_RD_SPLIT_PAGE_CHECK_EN enables the 4KB page boundary split.
module ofs_plat_host_chan_gen_rd_req_split
  import ofs_plat_host_chan_gen_rd_split_pkg::*;
#(
  parameter int ADDR_WIDTH = 64,
  parameter int TAG_WIDTH = 9,
  parameter int MAX_AFU_LINES = 64,
  parameter int LC_WIDTH = $clog2(MAX_AFU_LINES+1),
  parameter int MAX_RD_REQ_LINES = 8
)
(
  input  logic                  clk,
  input  logic                  reset,

  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  input  logic [LC_WIDTH-1:0]   in_line_count,

  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [TAG_WIDTH-1:0]  out_tag,
  output logic [LC_WIDTH-1:0]   out_line_count,
  output logic [LC_WIDTH-1:0]   out_line_offset,
  output logic                  out_sop,
  output logic                  out_eop
);

  localparam int LINE_SHIFT = $clog2(LINE_BYTES);

  t_rd_split_state       state_q;
  logic [LC_WIDTH-1:0]   remLines_q;
  logic [LC_WIDTH-1:0]   curOffset_q;
  logic [ADDR_WIDTH-1:0] curAddr_q;
  logic [TAG_WIDTH-1:0]  curTag_q;

  logic                  outValid_q;
  logic [ADDR_WIDTH-1:0] outAddr_q;
  logic [TAG_WIDTH-1:0]  outTag_q;
  logic [LC_WIDTH-1:0]   outLineCount_q;
  logic [LC_WIDTH-1:0]   outLineOffset_q;
  logic                  outSop_q;
  logic                  outEop_q;

  logic                  isIdle;
  logic                  outLoad;
  logic                  srcValid;
  logic [ADDR_WIDTH-1:0] srcAddr;
  logic [TAG_WIDTH-1:0]  srcTag;
  logic [LC_WIDTH:0]     srcRem;
  logic [LC_WIDTH-1:0]   srcOffset;
  logic [LC_WIDTH:0]     chunkLen;
  logic                  chunkEop;
  logic [LC_WIDTH:0]     remAfter_d;
  logic [ADDR_WIDTH-1:0] curAddr_d;
  logic [LC_WIDTH-1:0]   curOffset_d;
  logic                  unusedTopBits;

  assign isIdle  = (state_q == ST_IDLE);
  assign outLoad = !outValid_q || out_ready;
  assign in_ready = isIdle && outLoad;

  // A new request is the chunk source only while no split is in progress.
  always_comb begin
    srcValid  = isIdle ? in_valid : 1'b1;
    srcAddr   = isIdle ? in_addr : curAddr_q;
    srcTag    = isIdle ? in_tag : curTag_q;
    srcRem    = isIdle ? {1'b0, in_line_count} : {1'b0, remLines_q};
    srcOffset = isIdle ? '0 : curOffset_q;
  end

  ofs_plat_host_chan_rd_split_len #(
    .LC_WIDTH         (LC_WIDTH),
    .MAX_RD_REQ_LINES (MAX_RD_REQ_LINES)
  ) lenCalc (
`ifdef OFS_PLAT_HOST_CHAN_RD_SPLIT_PAGE_CHECK_EN
    .page_line_idx_i (srcAddr[11:6]),
`endif
    .remaining_i     (srcRem),
    .len_o           (chunkLen)
  );

  assign chunkEop    = (chunkLen == srcRem);
  assign remAfter_d  = srcRem - chunkLen;
  assign curAddr_d   = srcAddr + (ADDR_WIDTH'(chunkLen) << LINE_SHIFT);
  assign curOffset_d = srcOffset + chunkLen[LC_WIDTH-1:0];
  assign unusedTopBits = ^{chunkLen[LC_WIDTH], remAfter_d[LC_WIDTH]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      remLines_q  <= '0;
      curOffset_q <= '0;
      outValid_q  <= 1'b0;
    end else if (outLoad) begin
      outValid_q <= srcValid;
      if (srcValid) begin
        outAddr_q       <= srcAddr;
        outTag_q        <= srcTag;
        outLineCount_q  <= chunkLen[LC_WIDTH-1:0];
        outLineOffset_q <= srcOffset;
        outSop_q        <= isIdle;
        outEop_q        <= chunkEop;
        curAddr_q       <= curAddr_d;
        curTag_q        <= srcTag;
        curOffset_q     <= curOffset_d;
        remLines_q      <= remAfter_d[LC_WIDTH-1:0];
        state_q         <= chunkEop ? ST_IDLE : ST_SPLIT;
      end
    end
  end

  assign out_valid       = outValid_q;
  assign out_addr        = outAddr_q;
  assign out_tag         = outTag_q;
  assign out_line_count  = outLineCount_q;
  assign out_line_offset = outLineOffset_q;
  assign out_sop         = outSop_q;
  assign out_eop         = outEop_q;

  inLineCountNonZero: assert property (@(posedge clk) disable iff (reset)
    (in_valid && in_ready) |-> (in_line_count != '0))
    else $fatal(1, "zero-length read request accepted");

endmodule

// File: tb/tb_ofs_plat_host_chan_gen_rd_req_split.sv
// Self-checking bench for the read request splitter: queue-based chunk model plus directed literals.
// Expectations follow OFS_PLAT_HOST_CHAN_RD_SPLIT_PAGE_CHECK_EN the same way the design does.
module tb_ofs_plat_host_chan_gen_rd_req_split;
  import ofs_plat_host_chan_gen_rd_split_pkg::*;

  localparam int ADDR_WIDTH = 64;
  localparam int TAG_WIDTH = 9;
  localparam int MAX_AFU_LINES = 64;
  localparam int LC_WIDTH = 7;
  localparam int MAX_RD = 8;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  in_valid;
  logic                  in_ready;
  logic [ADDR_WIDTH-1:0] in_addr;
  logic [TAG_WIDTH-1:0]  in_tag;
  logic [LC_WIDTH-1:0]   in_line_count;
  logic                  out_valid;
  logic                  out_ready;
  logic [ADDR_WIDTH-1:0] out_addr;
  logic [TAG_WIDTH-1:0]  out_tag;
  logic [LC_WIDTH-1:0]   out_line_count;
  logic [LC_WIDTH-1:0]   out_line_offset;
  logic                  out_sop;
  logic                  out_eop;

  int checks = 0;
  int errors = 0;
  int cycleCnt = 0;
  bit randReady = 1'b0;
  bit forcedReady = 1'b1;

  t_rd_split_chunk expQ[$];
  t_rd_split_chunk obsQ[$];
  int              obsCycQ[$];
  int              acceptCycQ[$];

  ofs_plat_host_chan_gen_rd_req_split #(
    .ADDR_WIDTH       (ADDR_WIDTH),
    .TAG_WIDTH        (TAG_WIDTH),
    .MAX_AFU_LINES    (MAX_AFU_LINES),
    .LC_WIDTH         (LC_WIDTH),
    .MAX_RD_REQ_LINES (MAX_RD)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_addr         (in_addr),
    .in_tag          (in_tag),
    .in_line_count   (in_line_count),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_addr        (out_addr),
    .out_tag         (out_tag),
    .out_line_count  (out_line_count),
    .out_line_offset (out_line_offset),
    .out_sop         (out_sop),
    .out_eop         (out_eop)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt++;

  // Downstream backpressure: random in the soak phase, scripted in directed tests.
  always @(posedge clk) begin
    #2;
    out_ready = randReady ? ($urandom_range(0, 9) < 7) : forcedReady;
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Reference split: walk the request, cutting at the cap and (optionally) at each 4KB page end.
  function automatic void modelSplit(input logic [63:0] addr, input logic [8:0] tag, input int lines);
    int rem;
    int off;
    int len;
    int room;
    logic [63:0] a;
    t_rd_split_chunk c;
    rem = lines;
    off = 0;
    a = addr;
    while (rem > 0) begin
      len = (rem < MAX_RD) ? rem : MAX_RD;
`ifdef OFS_PLAT_HOST_CHAN_RD_SPLIT_PAGE_CHECK_EN
      room = 64 - int'((a % 64'd4096) / 64'd64);
      if (room < len) len = room;
`else
      room = 0;
`endif
      c.addr = a;
      c.tag = tag;
      c.line_count = 7'(len);
      c.line_offset = 7'(off);
      c.sop = (off == 0);
      c.eop = (len == rem);
      expQ.push_back(c);
      a = a + 64'(len * 64);
      off += len;
      rem -= len;
    end
  endfunction

  t_rd_split_chunk stallChunk;
  t_rd_split_chunk curChunk;
  t_rd_split_chunk expChunk;
  bit prevStall = 1'b0;

  always @(negedge clk) begin
    curChunk.addr = out_addr;
    curChunk.tag = out_tag;
    curChunk.line_count = out_line_count;
    curChunk.line_offset = out_line_offset;
    curChunk.sop = out_sop;
    curChunk.eop = out_eop;
    if (reset) begin
      expQ.delete();
      prevStall = 1'b0;
    end else begin
      if (prevStall) begin
        checkOutput("stall_valid", 64'(out_valid), 64'd1);
        checkOutput("stall_fields", 64'(curChunk != stallChunk), 64'd0);
      end
      if (in_valid && in_ready) begin
        modelSplit(in_addr, in_tag, int'(in_line_count));
        acceptCycQ.push_back(cycleCnt);
      end
      if (out_valid && out_ready) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_chunk: actual addr 0x%0h required none", out_addr);
        end else begin
          expChunk = expQ.pop_front();
          checkOutput("chunk_addr", out_addr, expChunk.addr);
          checkOutput("chunk_tag", 64'(out_tag), 64'(expChunk.tag));
          checkOutput("chunk_lines", 64'(out_line_count), 64'(expChunk.line_count));
          checkOutput("chunk_offset", 64'(out_line_offset), 64'(expChunk.line_offset));
          checkOutput("chunk_sop", 64'(out_sop), 64'(expChunk.sop));
          checkOutput("chunk_eop", 64'(out_eop), 64'(expChunk.eop));
        end
        obsQ.push_back(curChunk);
        obsCycQ.push_back(cycleCnt);
      end
      prevStall = out_valid && !out_ready;
      stallChunk = curChunk;
    end
  end

  task automatic applyStimulus(input logic [63:0] addr, input logic [8:0] tag, input int lines);
    bit accepted;
    int waited;
    accepted = 1'b0;
    waited = 0;
    in_valid = 1'b1;
    in_addr = addr;
    in_tag = tag;
    in_line_count = 7'(lines);
    while (!accepted && waited < 300) begin
      @(negedge clk);
      accepted = in_ready;
      @(posedge clk);
      #1;
      waited++;
    end
    in_valid = 1'b0;
    if (!accepted) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: actual in_ready 0 required 1 for addr 0x%0h", addr);
    end
  endtask

  task automatic waitIdle(input string name);
    bit done;
    int waited;
    done = 1'b0;
    waited = 0;
    while (!done && waited < 1000) begin
      @(negedge clk);
      done = (expQ.size() == 0) && !out_valid && in_ready;
      waited++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_drain_timeout: actual %0d chunks pending required 0", name, expQ.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic checkChunk(input string name, input int idx, input logic [63:0] addr,
                            input int lines, input int off, input bit sop, input bit eop);
    if (idx >= obsQ.size()) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_missing: actual %0d chunks required index %0d", name, obsQ.size(), idx);
    end else begin
      checkOutput({name, "_addr"}, obsQ[idx].addr, addr);
      checkOutput({name, "_lines"}, 64'(obsQ[idx].line_count), 64'(lines));
      checkOutput({name, "_offset"}, 64'(obsQ[idx].line_offset), 64'(off));
      checkOutput({name, "_sop"}, 64'(obsQ[idx].sop), 64'(sop));
      checkOutput({name, "_eop"}, 64'(obsQ[idx].eop), 64'(eop));
    end
  endtask

  task automatic clearLogs();
    obsQ.delete();
    obsCycQ.delete();
    acceptCycQ.delete();
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int spurious;
    logic [63:0] rAddr;
    reset = 1'b1;
    in_valid = 1'b0;
    in_addr = '0;
    in_tag = '0;
    in_line_count = 7'd1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Single full-cap chunk, one-cycle latency.
    clearLogs();
    applyStimulus(64'h1000, 9'h011, 8);
    waitIdle("t1");
    checkOutput("t1_nchunks", 64'(obsQ.size()), 64'd1);
    checkChunk("t1_c0", 0, 64'h1000, 8, 0, 1'b1, 1'b1);
    if (obsCycQ.size() > 0 && acceptCycQ.size() > 0)
      checkOutput("t1_latency", 64'(obsCycQ[0] - acceptCycQ[0]), 64'd1);

    // 20 lines from 0 split into 8/8/4.
    clearLogs();
    applyStimulus(64'h0, 9'h0A2, 20);
    waitIdle("t2");
    checkOutput("t2_nchunks", 64'(obsQ.size()), 64'd3);
    checkChunk("t2_c0", 0, 64'h0, 8, 0, 1'b1, 1'b0);
    checkChunk("t2_c1", 1, 64'h200, 8, 8, 1'b0, 1'b0);
    checkChunk("t2_c2", 2, 64'h400, 4, 16, 1'b0, 1'b1);

    // Request straddling a 4KB page end.
    clearLogs();
    applyStimulus(64'h1FC0, 9'h033, 4);
    waitIdle("t3");
`ifdef OFS_PLAT_HOST_CHAN_RD_SPLIT_PAGE_CHECK_EN
    checkOutput("t3_nchunks", 64'(obsQ.size()), 64'd2);
    checkChunk("t3_c0", 0, 64'h1FC0, 1, 0, 1'b1, 1'b0);
    checkChunk("t3_c1", 1, 64'h2000, 3, 1, 1'b0, 1'b1);
`else
    checkOutput("t3_nchunks", 64'(obsQ.size()), 64'd1);
    checkChunk("t3_c0", 0, 64'h1FC0, 4, 0, 1'b1, 1'b1);
`endif

    // Backpressure on the second chunk of a 20-line request.
    clearLogs();
    applyStimulus(64'h0, 9'h044, 20);
    @(posedge clk);
    #1;
    forcedReady = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      checkOutput("t4_hold_addr", out_addr, 64'h200);
      checkOutput("t4_hold_valid", 64'(out_valid), 64'd1);
      checkOutput("t4_in_ready", 64'(in_ready), 64'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    forcedReady = 1'b1;
    waitIdle("t4");
    checkOutput("t4_nchunks", 64'(obsQ.size()), 64'd3);
    checkChunk("t4_c0", 0, 64'h0, 8, 0, 1'b1, 1'b0);
    checkChunk("t4_c1", 1, 64'h200, 8, 8, 1'b0, 1'b0);
    checkChunk("t4_c2", 2, 64'h400, 4, 16, 1'b0, 1'b1);

    // 16 back-to-back single-line requests at full rate.
    clearLogs();
    for (int i = 0; i < 16; i++) applyStimulus(64'h4000 + 64'(i * 64), 9'(9'h100 + i), 1);
    waitIdle("t5");
    checkOutput("t5_nchunks", 64'(obsQ.size()), 64'd16);
    if (obsCycQ.size() == 16) checkOutput("t5_span", 64'(obsCycQ[15] - obsCycQ[0]), 64'd15);
    for (int i = 0; i < obsQ.size(); i++) checkOutput("t5_tag", 64'(obsQ[i].tag), 64'(9'h100 + i));

    // Reset in the middle of a split drops the rest.
    clearLogs();
    applyStimulus(64'h0, 9'h055, 20);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("t6_out_valid", 64'(out_valid), 64'd0);
    spurious = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) spurious++;
    end
    checkOutput("t6_no_chunks", 64'(spurious), 64'd0);
    checkOutput("t6_in_ready", 64'(in_ready), 64'd1);
    checkOutput("t6_nchunks", 64'(obsQ.size()), 64'd1);
    @(posedge clk);
    #1;

    // Randomized soak against the model, including top-of-address-space wrap.
    randReady = 1'b1;
    for (int n = 0; n < 80; n++) begin
      case ($urandom_range(0, 3))
        0: rAddr = {$urandom, $urandom} & ~64'h3F;
        1: rAddr = 64'hFFFF_FFFF_FFFF_F000 | (64'($urandom_range(40, 63)) << 6);
        2: rAddr = (64'($urandom_range(0, 255)) << 12) | (64'($urandom_range(50, 63)) << 6);
        default: rAddr = 64'($urandom_range(0, 1023)) << 6;
      endcase
      applyStimulus(rAddr, 9'($urandom), $urandom_range(1, 64));
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    waitIdle("rand");
    randReady = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
